// File: rtl/uart_tx_fifo_if.sv
// Write-side bus between the CPU register logic and the buffered UART transmitter.
// The master drives bytes and the overflow clear; the slave reports occupancy and status.
interface uart_tx_fifo_if #(
   parameter int ADDR_W = 4
);
   logic [7:0]      wr_data;
   logic            wr_en;
   logic            clr_overflow;
   logic            wr_full;
   logic [ADDR_W:0] wr_count;
   logic            overflow;

   modport master (
      output wr_data, wr_en, clr_overflow,
      input  wr_full, wr_count, overflow
   );

   modport slave (
      input  wr_data, wr_en, clr_overflow,
      output wr_full, wr_count, overflow
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a 2**ADDR_W-deep byte FIFO drained by a bit serializer
// onto uart_tx. Everything runs on clk50 with a synchronous active-low reset.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 4
) (
   input  logic           clk50,
   input  logic           reset_n,
   uart_tx_fifo_if.slave  wr_bus,
   output logic           uart_tx,
   output logic           tx_busy
);
   localparam int              DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);
   localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]      mem [0:DEPTH-1];
   logic [ADDR_W:0] wr_ptr_reg;
   logic [ADDR_W:0] rd_ptr_reg;
   logic [ADDR_W:0] count;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            overflow_reg;

   state_t          state_reg;
   logic [15:0]     baud_cnt_reg;
   logic [2:0]      bit_idx_reg;
   logic [7:0]      shreg_reg;
   logic            uart_tx_reg;
   logic            tx_busy_reg;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count = wr_ptr_reg - rd_ptr_reg;
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign push  = wr_bus.wr_en && !full;
   assign pop   = (state_reg == IDLE) && !empty;

   assign wr_bus.wr_full  = full;
   assign wr_bus.wr_count = count;
   assign wr_bus.overflow = overflow_reg;
   assign uart_tx         = uart_tx_reg;
   assign tx_busy         = tx_busy_reg;

   always_ff @(posedge clk50) begin
      if (push) begin
         mem[wr_ptr_reg[ADDR_W-1:0]] <= wr_bus.wr_data;
      end
   end

   always_ff @(posedge clk50) begin
      if (!reset_n) begin
         wr_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         // A dropped write beats a simultaneous clear.
         if (wr_bus.wr_en && full) begin
            overflow_reg <= 1'b1;
         end else if (wr_bus.clr_overflow) begin
            overflow_reg <= 1'b0;
         end
      end
   end

   // The line and busy flag are registered from the current state, so both trail the
   // FSM by one cycle and busy drops on the same edge the stop bit ends on the pin.
   always_ff @(posedge clk50) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         rd_ptr_reg   <= '0;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         shreg_reg    <= '0;
         uart_tx_reg  <= 1'b1;
         tx_busy_reg  <= 1'b0;
      end else begin
         tx_busy_reg <= (state_reg != IDLE) || !empty;
         case (state_reg)
            IDLE: begin
               uart_tx_reg <= 1'b1;
               if (pop) begin
                  shreg_reg    <= mem[rd_ptr_reg[ADDR_W-1:0]];
                  rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
                  baud_cnt_reg <= '0;
                  bit_idx_reg  <= '0;
                  state_reg    <= START;
               end
            end
            START: begin
               uart_tx_reg <= 1'b0;
               if (baud_cnt_reg == BAUD_LAST) begin
                  baud_cnt_reg <= '0;
                  state_reg    <= DATA;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 16'd1;
               end
            end
            DATA: begin
               uart_tx_reg <= shreg_reg[0];
               if (baud_cnt_reg == BAUD_LAST) begin
                  baud_cnt_reg <= '0;
                  shreg_reg    <= shreg_reg >> 1;
                  bit_idx_reg  <= bit_idx_reg + 3'd1;
                  if (bit_idx_reg == 3'd7) begin
                     state_reg <= STOP;
                  end
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 16'd1;
               end
            end
            STOP: begin
               uart_tx_reg <= 1'b1;
               if (baud_cnt_reg == BAUD_LAST) begin
                  baud_cnt_reg <= '0;
                  state_reg    <= IDLE;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 16'd1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end
endmodule
